multicycle_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the LD/SD/ADD/SUB/AND/OR/BEQ core; replaces per-instruction single-cycle decode.

---
 rtl/multicycle_control_fsm_if.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory port.
// The sequencer connects through "master"; the datapath side uses "slave".
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       mem_timeout;
    logic       halted;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_control, reg_write, mem_to_reg, illegal_op,
               mem_timeout, halted
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_control, reg_write, mem_to_reg, illegal_op,
               mem_timeout, halted
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH..WB sequencer for the LD/SD/ADD/SUB/AND/OR/BEQ core.
// Define MC_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
`ifndef OP_R_TYPE
`define OP_R_TYPE 7'b0110011
`endif
`ifndef OP_I_TYPE
`define OP_I_TYPE 7'b0000011
`endif
`ifndef OP_S_TYPE
`define OP_S_TYPE 7'b0100011
`endif
`ifndef OP_B_TYPE
`define OP_B_TYPE 7'b1100011
`endif
`ifndef FUNC3_ADD_SUB
`define FUNC3_ADD_SUB 3'b000
`endif
`ifndef FUNC3_AND
`define FUNC3_AND 3'b111
`endif
`ifndef FUNC3_OR
`define FUNC3_OR 3'b110
`endif
`ifndef FUNC7_SUB
`define FUNC7_SUB 7'b0100000
`endif
`ifndef ALU_AND
`define ALU_AND 3'b000
`endif
`ifndef ALU_OR
`define ALU_OR 3'b001
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b010
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b110
`endif

module multicycle_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX    = 15,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    multicycle_control_fsm_if.master        ctl
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]                     cycle_cnt,
    output logic [31:0]                     retired_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_ACC, LOAD_WB, EXEC_R, R_WB, BRANCH, HALT
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = MEM_WAIT_MAX[7:0];

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       wait_expire;
    logic       timeout_hit;
    logic       timeout_q;
    logic [2:0] r_alu, r_alu_q;
    logic       is_store;

    // Expiry is judged on the cycle that would make the count reach the limit.
    assign wait_expire = (wait_cnt >= (WAIT_LIMIT - 8'd1));
    assign is_store    = (ctl.opcode == `OP_S_TYPE);

    always_comb begin
        r_alu = `ALU_ADD;
        case (ctl.funct3)
            `FUNC3_ADD_SUB: r_alu = (ctl.funct7 == `FUNC7_SUB) ? `ALU_SUB : `ALU_ADD;
            `FUNC3_AND:     r_alu = `ALU_AND;
            `FUNC3_OR:      r_alu = `ALU_OR;
            default:        r_alu = `ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
            r_alu_q   <= `ALU_ADD;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= 8'd0;
            else if (ctl.mem_req && !ctl.mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit)
                timeout_q <= 1'b1;
            if (state == EXEC_R)
                r_alu_q <= r_alu;
        end
    end

    // Every output is forced low while reset is asserted, including alu_control.
    always_comb begin
        state_next      = state;
        timeout_hit     = 1'b0;
        ctl.mem_req     = 1'b0;
        ctl.mem_we      = 1'b0;
        ctl.iord        = 1'b0;
        ctl.ir_write    = 1'b0;
        ctl.pc_write    = 1'b0;
        ctl.pc_src      = 1'b0;
        ctl.alu_src_a   = 1'b0;
        ctl.alu_src_b   = 2'b00;
        ctl.alu_control = `ALU_ADD;
        ctl.reg_write   = 1'b0;
        ctl.mem_to_reg  = 1'b0;
        ctl.illegal_op  = 1'b0;
        ctl.mem_timeout = timeout_q;
        ctl.halted      = 1'b0;
        if (rst) begin
            ctl.alu_control = 3'b000;
        end else begin
            case (state)
                FETCH: begin
                    ctl.mem_req   = 1'b1;
                    ctl.alu_src_b = 2'b01;
                    if (ctl.mem_ready) begin
                        ctl.ir_write = 1'b1;
                        ctl.pc_write = 1'b1;
                        state_next   = DECODE;
                    end else if (wait_expire) begin
                        timeout_hit = 1'b1;
                        state_next  = HALT;
                    end
                end
                DECODE: begin
                    ctl.alu_src_b = 2'b10;
                    case (ctl.opcode)
                        `OP_I_TYPE, `OP_S_TYPE: state_next = MEM_ADDR;
                        `OP_R_TYPE:             state_next = EXEC_R;
                        `OP_B_TYPE:             state_next = BRANCH;
                        default: begin
                            ctl.illegal_op = 1'b1;
                            state_next     = HALT_ON_ILLEGAL ? HALT : FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = 2'b10;
                    state_next    = MEM_ACC;
                end
                MEM_ACC: begin
                    ctl.mem_req = 1'b1;
                    ctl.iord    = 1'b1;
                    ctl.mem_we  = is_store;
                    if (ctl.mem_ready) begin
                        state_next = is_store ? FETCH : LOAD_WB;
                    end else if (wait_expire) begin
                        timeout_hit = 1'b1;
                        state_next  = HALT;
                    end
                end
                LOAD_WB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                    state_next     = FETCH;
                end
                EXEC_R: begin
                    ctl.alu_src_a   = 1'b1;
                    ctl.alu_control = r_alu;
                    state_next      = R_WB;
                end
                R_WB: begin
                    ctl.reg_write   = 1'b1;
                    ctl.alu_control = r_alu_q;
                    state_next      = FETCH;
                end
                BRANCH: begin
                    ctl.alu_src_a   = 1'b1;
                    ctl.alu_control = `ALU_SUB;
                    if (ctl.zero && (ctl.funct3 == 3'b000)) begin
                        ctl.pc_write = 1'b1;
                        ctl.pc_src   = 1'b1;
                    end
                    state_next = FETCH;
                end
                HALT: begin
                    ctl.halted = 1'b1;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state_next == FETCH) &&
                    ((state == LOAD_WB) || (state == R_WB) || (state == BRANCH) ||
                     ((state == MEM_ACC) && is_store));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            if (state != HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm (MEM_WAIT_MAX=15, HALT_ON_ILLEGAL=1).
// Honours MC_PERF_CNT_EN when the design is built with the counters.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    multicycle_control_fsm_if mif ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_control_fsm #(
        .MEM_WAIT_MAX    (15),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (mif)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset around a negedge, confirm outputs are all low, then land in the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.iord, mif.ir_write, mif.pc_write, mif.pc_src,
             mif.alu_src_a, mif.alu_src_b, mif.alu_control, mif.reg_write, mif.mem_to_reg,
             mif.illegal_op, mif.mem_timeout, mif.halted} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual mem_req=%b halted=%b timeout=%b alu=%b required all 0",
                     mif.mem_req, mif.halted, mif.mem_timeout, mif.alu_control);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
`ifdef MC_PERF_CNT_EN
        checks++;
        if ({cycle_cnt, retired_cnt} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters actual=%0d/%0d required=0/0", cycle_cnt, retired_cnt);
        end
`endif
        checks++;
        if ({mif.mem_req, mif.iord, mif.alu_src_a, mif.alu_src_b} !== 5'b10001) begin
            failures++;
            $display("[TB] FAIL first_fetch actual req/iord/a/b=%b%b%b%b required=1,0,0,01",
                     mif.mem_req, mif.iord, mif.alu_src_a, mif.alu_src_b);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b111, 3'b110};
        logic [6:0] f7s [4] = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000};
        logic [2:0] exp [4] = '{A_ADD, A_SUB, A_AND, A_OR};
        string      nm  [4] = '{"add", "sub", "and", "or"};
        for (int i = 0; i < 4; i++) begin
            mif.opcode = OP_R; mif.funct3 = f3s[i]; mif.funct7 = f7s[i]; mif.mem_ready = 1'b1;
            #1;
            checks++;
            if ({mif.ir_write, mif.pc_write, mif.pc_src} !== 3'b110) begin
                failures++;
                $display("[TB] FAIL %s_fetch actual ir/pc/src=%b%b%b required=110", nm[i],
                         mif.ir_write, mif.pc_write, mif.pc_src);
            end
            tick();
            checks++;
            if ({mif.mem_req, mif.alu_src_a, mif.alu_src_b} !== 4'b0010) begin
                failures++;
                $display("[TB] FAIL %s_decode actual req/a/b=%b%b%b required=0010", nm[i],
                         mif.mem_req, mif.alu_src_a, mif.alu_src_b);
            end
            tick();
            checks++;
            if ({mif.alu_control, mif.alu_src_a, mif.alu_src_b, mif.reg_write} !== {exp[i], 4'b1000}) begin
                failures++;
                $display("[TB] FAIL %s_exec actual alu=%b a=%b b=%b wr=%b required alu=%b a=1 b=00 wr=0",
                         nm[i], mif.alu_control, mif.alu_src_a, mif.alu_src_b, mif.reg_write, exp[i]);
            end
            tick();
            mif.funct3 = 3'b001;
            mif.funct7 = 7'b0000000;
            #1;
            checks++;
            if ({mif.alu_control, mif.reg_write, mif.mem_to_reg} !== {exp[i], 2'b10}) begin
                failures++;
                $display("[TB] FAIL %s_wb actual alu=%b wr=%b m2r=%b required alu=%b wr=1 m2r=0",
                         nm[i], mif.alu_control, mif.reg_write, mif.mem_to_reg, exp[i]);
            end
            tick();
            checks++;
            if ({mif.mem_req, mif.iord} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL %s_return actual req/iord=%b%b required=10", nm[i], mif.mem_req, mif.iord);
            end
        end
    endtask

    task automatic test_load_wait();
`ifdef MC_PERF_CNT_EN
        logic [31:0] cyc0 = cycle_cnt;
        logic [31:0] ret0 = retired_cnt;
`endif
        mif.opcode = OP_L; mif.funct3 = 3'b011; mif.mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({mif.alu_src_a, mif.alu_src_b, mif.mem_req} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL ld_addr actual a/b/req=%b%b%b required=1100",
                     mif.alu_src_a, mif.alu_src_b, mif.mem_req);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            mif.mem_ready = (i == 3);
            #1;
            checks++;
            if ({mif.mem_req, mif.iord, mif.mem_we} !== 3'b110) begin
                failures++;
                $display("[TB] FAIL ld_access_%0d actual req/iord/we=%b%b%b required=110", i,
                         mif.mem_req, mif.iord, mif.mem_we);
            end
            tick();
        end
        checks++;
        if ({mif.reg_write, mif.mem_to_reg, mif.mem_req} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL ld_wb actual wr/m2r/req=%b%b%b required=110",
                     mif.reg_write, mif.mem_to_reg, mif.mem_req);
        end
        tick();
        checks++;
        if ({mif.mem_req, mif.iord} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ld_return actual req/iord=%b%b required=10", mif.mem_req, mif.iord);
        end
`ifdef MC_PERF_CNT_EN
        checks++;
        if ((retired_cnt - ret0) !== 32'd1 || (cycle_cnt - cyc0) !== 32'd8) begin
            failures++;
            $display("[TB] FAIL ld_perf actual retired+%0d cycles+%0d required retired+1 cycles+8",
                     retired_cnt - ret0, cycle_cnt - cyc0);
        end
`endif
    endtask

    task automatic test_store();
        mif.opcode = OP_S; mif.funct3 = 3'b011; mif.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({mif.mem_req, mif.iord, mif.mem_we} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL sd_access actual req/iord/we=%b%b%b required=111",
                     mif.mem_req, mif.iord, mif.mem_we);
        end
        tick();
        checks++;
        if ({mif.mem_req, mif.iord, mif.mem_we, mif.reg_write} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL sd_return actual req/iord/we/wr=%b%b%b%b required=1000",
                     mif.mem_req, mif.iord, mif.mem_we, mif.reg_write);
        end
    endtask

    task automatic test_branch();
        logic       zs  [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] f3s [3] = '{3'b000, 3'b000, 3'b001};
        logic [1:0] exp [3] = '{2'b11, 2'b00, 2'b00};
        for (int i = 0; i < 3; i++) begin
            mif.opcode = OP_B; mif.funct3 = f3s[i]; mif.zero = zs[i]; mif.mem_ready = 1'b1;
            tick();
            tick();
            checks++;
            if ({mif.pc_write, mif.pc_src, mif.alu_control, mif.alu_src_a} !== {exp[i], A_SUB, 1'b1}) begin
                failures++;
                $display("[TB] FAIL beq_%0d actual pcw=%b src=%b alu=%b a=%b required pcw/src=%b alu=%b a=1",
                         i, mif.pc_write, mif.pc_src, mif.alu_control, mif.alu_src_a, exp[i], A_SUB);
            end
            tick();
            checks++;
            if ({mif.mem_req, mif.pc_write} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL beq_%0d_return actual req/pcw=%b%b required=11", i,
                         mif.mem_req, mif.pc_write);
            end
        end
        mif.zero = 1'b0;
    endtask

    task automatic test_illegal();
        mif.opcode = 7'h7F; mif.mem_ready = 1'b1;
        tick();
        checks++;
        if ({mif.illegal_op, mif.halted} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ill_decode actual ill/halted=%b%b required=10", mif.illegal_op, mif.halted);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({mif.illegal_op, mif.halted, mif.mem_req, mif.pc_write} !== 4'b0100) begin
                failures++;
                $display("[TB] FAIL ill_halt_%0d actual ill/halted/req/pcw=%b%b%b%b required=0100", i,
                         mif.illegal_op, mif.halted, mif.mem_req, mif.pc_write);
            end
        end
        mif.opcode = OP_R;
        do_reset();
        checks++;
        if ({mif.halted, mif.mem_req} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL ill_recover actual halted/req=%b%b required=01", mif.halted, mif.mem_req);
        end
    endtask

    task automatic test_timeout();
        mif.opcode = OP_R; mif.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if ({mif.mem_req, mif.mem_timeout, mif.halted} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL to_wait_%0d actual req/to/halted=%b%b%b required=100", i,
                         mif.mem_req, mif.mem_timeout, mif.halted);
            end
            tick();
        end
        checks++;
        if ({mif.halted, mif.mem_timeout, mif.mem_req} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL to_expired actual halted/to/req=%b%b%b required=110",
                     mif.halted, mif.mem_timeout, mif.mem_req);
        end
        do_reset();
        checks++;
        if ({mif.mem_timeout, mif.halted} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL to_cleared actual to/halted=%b%b required=00", mif.mem_timeout, mif.halted);
        end
    endtask

    task automatic test_timeout_boundary();
        mif.opcode = OP_R; mif.mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        mif.mem_ready = 1'b1;
        #1;
        checks++;
        if (mif.ir_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tob_ready actual ir_write=%b required=1", mif.ir_write);
        end
        tick();
        checks++;
        if ({mif.halted, mif.mem_timeout, mif.alu_src_b} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL tob_decode actual halted/to/b=%b%b%b required=0010",
                     mif.halted, mif.mem_timeout, mif.alu_src_b);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        mif.opcode = OP_R; mif.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mif.mem_req, mif.mem_timeout, mif.halted} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL arst_midwait actual req/to/halted=%b%b%b required=000",
                     mif.mem_req, mif.mem_timeout, mif.halted);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if ({mif.mem_req, mif.halted, mif.mem_timeout} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL arst_counter_clear actual req/halted/to=%b%b%b required=100",
                     mif.mem_req, mif.halted, mif.mem_timeout);
        end
        mif.mem_ready = 1'b1;
        do_reset();
    endtask

    initial begin
        rst           = 1'b1;
        mif.opcode    = OP_R;
        mif.funct3    = 3'b000;
        mif.funct7    = 7'b0000000;
        mif.zero      = 1'b0;
        mif.mem_ready = 1'b1;
        test_reset();
        test_alu_ops();
        test_load_wait();
        test_store();
        test_branch();
        test_illegal();
        test_timeout();
        test_timeout_boundary();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
